// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register file write port
//
// Shares one regfile write port between NREQ writeback sources. Each cycle the
// first valid requester after the previous winner is accepted, and its pointer
// and data are registered onto o_WE/o_RD_PTR/o_RD. A 32-entry pending-write
// scoreboard tracks reserved destinations for RAW/WAW stalls. A sticky flag
// records any write of x2 (sp) below SP_LIMIT.
//
// Ports:
//   i_CLK, i_RST_N                clock, asynchronous active-low reset
//   i_REQ_VALID / o_REQ_READY     per-requester handshake, ready one-hot
//   i_REQ_RD_PTR / i_REQ_RD       packed per-requester pointer (5b) and data (XLEN)
//   i_ISSUE_VALID/i_ISSUE_RD_PTR  scoreboard reservation from issue
//   i_RS1_PTR / i_RS2_PTR         hazard query pointers
//   o_RS1_BUSY/o_RS2_BUSY/o_RD_BUSY  scoreboard lookups (registered state only)
//   o_WE / o_RD_PTR / o_RD        registered regfile write port
//   o_SP_OVF                      sticky stack-overflow flag

module regfile_wb_arbiter #(
    parameter int              NREQ     = 3,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] SP_LIMIT = 32'h2000_0660
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_N,
    input  logic [NREQ-1:0]      i_REQ_VALID,
    output logic [NREQ-1:0]      o_REQ_READY,
    input  logic [NREQ*5-1:0]    i_REQ_RD_PTR,
    input  logic [NREQ*XLEN-1:0] i_REQ_RD,
    input  logic                 i_ISSUE_VALID,
    input  logic [4:0]           i_ISSUE_RD_PTR,
    input  logic [4:0]           i_RS1_PTR,
    input  logic [4:0]           i_RS2_PTR,
    output logic                 o_RS1_BUSY,
    output logic                 o_RS2_BUSY,
    output logic                 o_RD_BUSY,
    output logic                 o_WE,
    output logic [4:0]           o_RD_PTR,
    output logic [XLEN-1:0]      o_RD,
    output logic                 o_SP_OVF
);

    localparam int GW = $clog2(NREQ);

    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant_idx;
    logic            grant_found;
    logic [GW:0]     rr_sum;
    logic [4:0]      sel_ptr;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     scoreboard;
    logic [31:0]     sb_next;

    // Round-robin search: walk offsets 1..NREQ from the last winner, wrapping
    // modulo NREQ, so the previous winner is considered last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        rr_sum      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_sum = {1'b0, last_grant} + (GW+1)'(i);
            if (rr_sum >= (GW+1)'(NREQ)) begin
                rr_sum = rr_sum - (GW+1)'(NREQ);
            end
            if (!grant_found && i_REQ_VALID[rr_sum[GW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_sum[GW-1:0];
            end
        end
    end

    // Winner's pointer/data mux and one-hot ready.
    always_comb begin
        sel_ptr     = '0;
        sel_data    = '0;
        o_REQ_READY = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == GW'(k)) begin
                sel_ptr        = i_REQ_RD_PTR[5*k +: 5];
                sel_data       = i_REQ_RD[XLEN*k +: XLEN];
                o_REQ_READY[k] = grant_found;
            end
        end
    end

    // Clear on writeback first, then set on issue, so a same-cycle reissue of
    // the same register (a newer producer) keeps the bit set. x0 never pends.
    always_comb begin
        sb_next = scoreboard;
        if (grant_found) begin
            sb_next[sel_ptr] = 1'b0;
        end
        if (i_ISSUE_VALID) begin
            sb_next[i_ISSUE_RD_PTR] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    assign o_RS1_BUSY = scoreboard[i_RS1_PTR];
    assign o_RS2_BUSY = scoreboard[i_RS2_PTR];
    assign o_RD_BUSY  = scoreboard[i_ISSUE_RD_PTR];

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            o_WE       <= 1'b0;
            o_RD_PTR   <= '0;
            o_RD       <= '0;
            o_SP_OVF   <= 1'b0;
            scoreboard <= '0;
            last_grant <= GW'(NREQ-1);
        end else begin
            o_WE       <= grant_found;
            scoreboard <= sb_next;
            if (grant_found) begin
                o_RD_PTR   <= sel_ptr;
                o_RD       <= sel_data;
                last_grant <= grant_idx;
                if (sel_ptr == 5'd2 && sel_data < SP_LIMIT) begin
                    o_SP_OVF <= 1'b1;
                end
            end
        end
    end

endmodule
